// File: rtl/ptp_ts_queue_ctrl.sv
// PTP timestamp queue controller.
// Captures the RTC at each start of packet and, when the parser flags a PTP
// event message for that packet, pushes {timestamp, parser info} into a
// first-word-fall-through queue. The host pops entries with q_rd_en.
// Handshake: a push is offered once per packet; an entry is accepted whenever
// the queue is not full or a pop happens in the same cycle. A pop happens only
// when q_rd_en=1 and q_empty=0, and q_data always shows the head entry while
// q_empty=0.
module ptp_ts_queue_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int OVF_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  int_valid,
  input  logic                  int_sop,
  input  logic                  int_eop,
  input  logic [63:0]           rtc_time,
  input  logic                  ptp_found,
  input  logic [31:0]           ptp_infor,
  input  logic                  q_rd_en,
  input  logic                  q_flush,
  output logic [95:0]           q_data,
  output logic [DEPTH_LOG2:0]   q_cnt,
  output logic                  q_empty,
  output logic                  q_full,
  output logic [OVF_W-1:0]      q_ovf_cnt,
  output logic [1:0]            fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic        sop;
  logic        push_req;
  logic [63:0] ts_hold;
  logic        push_pend;
  logic [95:0] push_data;

  logic [95:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_next;
  logic [DEPTH_LOG2:0]   cnt_next;
  logic                  pop, wr_en, ovf_hit;

  // End of packet carries no meaning for timestamping.
  logic unused_eop;
  assign unused_eop = int_eop;

  assign sop       = int_valid && int_sop;
  assign fsm_state = state;

  // Next-state: every sop re-arms; the first ptp_found after it (never in the
  // sop cycle, where the flag is stale) requests exactly one push.
  always_comb begin
    state_next = state;
    push_req   = 1'b0;
    if (sop) begin
      state_next = ST_ARMED;
    end else if (state == ST_ARMED && ptp_found) begin
      push_req   = 1'b1;
      state_next = ST_DONE;
    end
  end

  // State register, timestamp capture and the one-cycle push staging stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ts_hold   <= '0;
      push_pend <= 1'b0;
      push_data <= '0;
    end else begin
      state     <= state_next;
      push_pend <= push_req;
      if (sop) ts_hold <= rtc_time;
      if (push_req) push_data <= {ts_hold, ptp_infor};
    end
  end

  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == FULL_CNT);
  assign pop     = q_rd_en && !q_empty;
  assign wr_en   = push_pend && (!q_full || pop);
  assign ovf_hit = push_pend && q_full && !pop;
  assign rd_next = pop ? rd_ptr + PTR_ONE : rd_ptr;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_next = q_cnt;
    case ({wr_en, pop})
      2'b10:   cnt_next = q_cnt + CNT_ONE;
      2'b01:   cnt_next = q_cnt - CNT_ONE;
      default: cnt_next = q_cnt;
    endcase
  end

  // Storage array; a flush or reset discards the staged entry.
  always_ff @(posedge clk) begin
    if (wr_en && !q_flush && !rst) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy, overflow counter and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_cnt     <= '0;
      q_ovf_cnt <= '0;
      q_data    <= '0;
    end else if (q_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_cnt     <= '0;
      q_ovf_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_next;
      q_cnt  <= cnt_next;
      if (ovf_hit && q_ovf_cnt != '1) q_ovf_cnt <= q_ovf_cnt + OVF_W'(1);
      // The new head is the entry being written when it lands in the head slot.
      if (cnt_next != '0) begin
        if (wr_en && wr_ptr == rd_next) q_data <= push_data;
        else                            q_data <= mem[rd_next];
      end
    end
  end

endmodule

// File: tb/tb_ptp_ts_queue_ctrl.sv
// Self-checking bench for ptp_ts_queue_ctrl.
module tb_ptp_ts_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_valid, int_sop, int_eop;
  logic [63:0] rtc_time;
  logic        ptp_found;
  logic [31:0] ptp_infor;
  logic        q_rd_en, q_flush;
  logic [95:0] q_data;
  logic [4:0]  q_cnt;
  logic        q_empty, q_full;
  logic [7:0]  q_ovf_cnt;
  logic [1:0]  fsm_state;

  logic [95:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  ptp_ts_queue_ctrl #(.DEPTH_LOG2(4), .OVF_W(8)) dut (
    .clk(clk), .rst(rst), .int_valid(int_valid), .int_sop(int_sop),
    .int_eop(int_eop), .rtc_time(rtc_time), .ptp_found(ptp_found),
    .ptp_infor(ptp_infor), .q_rd_en(q_rd_en), .q_flush(q_flush),
    .q_data(q_data), .q_cnt(q_cnt), .q_empty(q_empty), .q_full(q_full),
    .q_ovf_cnt(q_ovf_cnt), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 ns after the rising edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sop_beat(input logic [63:0] ts);
    int_valid = 1'b1;
    int_sop   = 1'b1;
    rtc_time  = ts;
    tick();
    int_sop   = 1'b0;
    ptp_found = 1'b0;
  endtask

  // Sop, then `gap` body cycles, then ptp_found rises and is sampled on the
  // next edge (the push edge). Returns 1 ns after that edge with ptp_found held.
  task automatic ptp_pkt(input logic [63:0] ts, input logic [31:0] infor, input int gap);
    sop_beat(ts);
    repeat (gap) tick();
    ptp_found = 1'b1;
    ptp_infor = infor;
    tick();
  endtask

  task automatic end_pkt();
    ptp_found = 1'b0;
    int_eop   = 1'b1;
    tick();
    int_eop   = 1'b0;
    int_valid = 1'b0;
  endtask

  // Scoreboard read: compare the head with the oldest expected entry, then pop it.
  task automatic read_one(input string name);
    logic [95:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, q_data=%h", name, q_data);
    end else begin
      exp = exp_q.pop_front();
      if (q_empty !== 1'b0 || q_data !== exp) begin
        n_fail++;
        $display("FAIL %s: q_data=%h q_empty=%b, expected %h q_empty=0", name, q_data, q_empty, exp);
      end
    end
    q_rd_en = 1'b1;
    tick();
    q_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; int_valid = 0; int_sop = 0; int_eop = 0; rtc_time = '0;
    ptp_found = 0; ptp_infor = '0; q_rd_en = 0; q_flush = 0;
    repeat (3) tick();
    rst = 1'b0;
    n_checks++;
    if (q_cnt !== 5'd0 || q_empty !== 1'b1 || q_full !== 1'b0 || q_ovf_cnt !== 8'd0 ||
        q_data !== 96'd0 || fsm_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: cnt=%0d empty=%b full=%b ovf=%0d data=%h st=%0d, expected 0 1 0 0 0 0",
               q_cnt, q_empty, q_full, q_ovf_cnt, q_data, fsm_state);
    end
    // ptp_found while idle pushes nothing.
    ptp_found = 1'b1; ptp_infor = 32'hDEAD_BEEF;
    repeat (4) tick();
    ptp_found = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (q_cnt !== 5'd0 || fsm_state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_found: cnt=%0d st=%0d, expected 0 0", q_cnt, fsm_state);
    end
  endtask

  task automatic test_single();
    exp_q.push_back(96'h0000_0010_0000_0100_1ABC_0007);
    ptp_pkt(64'h0000_0010_0000_0100, 32'h1ABC_0007, 2);
    n_checks++;
    if (q_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL push_latency: q_empty=%b at push edge, expected 1", q_empty);
    end
    tick();
    n_checks++;
    if (q_cnt !== 5'd1 || q_empty !== 1'b0 || fsm_state !== 2'd2) begin
      n_fail++;
      $display("FAIL single_cnt: cnt=%0d empty=%b st=%0d, expected 1 0 2", q_cnt, q_empty, fsm_state);
    end
    end_pkt();
    read_one("single_data");
    n_checks++;
    if (q_empty !== 1'b1 || q_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop: cnt=%0d empty=%b, expected 0 1", q_cnt, q_empty);
    end
  endtask

  task automatic test_stale_found();
    exp_q.push_back({64'h0000_0020_0000_0200, 32'h0101_0001});
    ptp_pkt(64'h0000_0020_0000_0200, 32'h0101_0001, 1);
    repeat (20) tick();
    exp_q.push_back({64'h0000_0021_0000_0300, 32'h0101_0002});
    ptp_pkt(64'h0000_0021_0000_0300, 32'h0101_0002, 3);
    end_pkt();
    repeat (10) tick();
    n_checks++;
    if (q_cnt !== 5'd2) begin
      n_fail++;
      $display("FAIL stale_cnt: cnt=%0d, expected 2", q_cnt);
    end
    read_one("stale_e1");
    read_one("stale_e2");
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) exp_q.push_back({64'h0000_0100_0000_0000 + 64'(i), 32'(i)});
      ptp_pkt(64'h0000_0100_0000_0000 + 64'(i), 32'(i), 1);
      end_pkt();
    end
    tick();
    n_checks++;
    if (q_full !== 1'b1 || q_cnt !== 5'd16 || q_ovf_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL fill: full=%b cnt=%0d ovf=%0d, expected 1 16 1", q_full, q_cnt, q_ovf_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    logic [95:0] exp;
    ptp_pkt(64'h0000_0200_0000_0018, 32'h0000_0018, 1);
    ptp_found = 1'b0;
    // Push lands on the next edge; pop on that same edge.
    n_checks++;
    exp = exp_q.pop_front();
    if (q_data !== exp) begin
      n_fail++;
      $display("FAIL fullpp_head: q_data=%h, expected %h", q_data, exp);
    end
    exp_q.push_back({64'h0000_0200_0000_0018, 32'h0000_0018});
    q_rd_en = 1'b1;
    tick();
    q_rd_en = 1'b0;
    n_checks++;
    if (q_cnt !== 5'd16 || q_full !== 1'b1 || q_ovf_cnt !== 8'd1 || q_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL fullpp: cnt=%0d full=%b ovf=%0d data=%h, expected 16 1 1 %h",
               q_cnt, q_full, q_ovf_cnt, q_data, exp_q[0]);
    end
    end_pkt();
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      read_one("drain");
    end
    n_checks++;
    if (q_empty !== 1'b1 || q_ovf_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL drained: empty=%b ovf=%0d, expected 1 1", q_empty, q_ovf_cnt);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      ptp_pkt(64'h0000_0300_0000_0000 + 64'(i), 32'hF000_0000 + 32'(i), 1);
      end_pkt();
    end
    tick();
    n_checks++;
    if (q_cnt !== 5'd5) begin
      n_fail++;
      $display("FAIL flush_pre: cnt=%0d, expected 5", q_cnt);
    end
    ptp_pkt(64'h0000_0300_0000_0099, 32'hF000_0099, 1);
    ptp_found = 1'b0;
    q_flush = 1'b1;
    tick();
    q_flush = 1'b0;
    n_checks++;
    if (q_cnt !== 5'd0 || q_empty !== 1'b1 || q_ovf_cnt !== 8'd0 || q_full !== 1'b0 ||
        fsm_state !== 2'd2) begin
      n_fail++;
      $display("FAIL flush: cnt=%0d empty=%b ovf=%0d full=%b st=%0d, expected 0 1 0 0 2",
               q_cnt, q_empty, q_ovf_cnt, q_full, fsm_state);
    end
    end_pkt();
    // Read of an empty queue must change nothing.
    q_rd_en = 1'b1;
    tick();
    q_rd_en = 1'b0;
    n_checks++;
    if (q_cnt !== 5'd0 || q_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_read: cnt=%0d empty=%b, expected 0 1", q_cnt, q_empty);
    end
    exp_q.push_back({64'h0000_0301_0000_0001, 32'h0A0A_0A0A});
    ptp_pkt(64'h0000_0301_0000_0001, 32'h0A0A_0A0A, 2);
    end_pkt();
    read_one("post_flush");
  endtask

  task automatic test_reset_armed();
    sop_beat(64'h0000_0400_0000_0001);
    n_checks++;
    if (fsm_state !== 2'd1) begin
      n_fail++;
      $display("FAIL armed: st=%0d, expected 1", fsm_state);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptp_found = 1'b1; ptp_infor = 32'h7777_7777;
    repeat (4) tick();
    n_checks++;
    if (fsm_state !== 2'd0 || q_empty !== 1'b1 || q_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_armed: st=%0d empty=%b cnt=%0d, expected 0 1 0", fsm_state, q_empty, q_cnt);
    end
    end_pkt();
  endtask

  task automatic test_back_to_back();
    logic [63:0] ts;
    logic [31:0] inf;
    for (int i = 0; i < 12; i++) begin
      ts  = {$urandom, $urandom};
      inf = $urandom;
      exp_q.push_back({ts, inf});
      ptp_pkt(ts, inf, $urandom_range(0, 3));
      ptp_found = 1'b0;
      if (exp_q.size() >= 2 && $urandom_range(0, 1) == 1) read_one("b2b_mid");
    end
    end_pkt();
    tick();
    while (exp_q.size() > 0) read_one("b2b_drain");
    n_checks++;
    if (q_empty !== 1'b1 || q_ovf_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_end: empty=%b ovf=%0d, expected 1 0", q_empty, q_ovf_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stale_found();
    test_fill_overflow();
    test_full_push_pop();
    test_flush();
    test_reset_armed();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
